// File: rtl/ife_pkg.sv
// ============================================================================
// Module      : ife_pkg
// Description : Default widths and block record type for the fetch block FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ife_pkg;

  localparam int IFE_BLOCK_ID_WIDTH = 8;
  localparam int IFE_INSTR_WIDTH    = 32;
  localparam int IFE_BLOCK_SIZE     = 4;

  typedef struct packed {
    logic [IFE_BLOCK_ID_WIDTH-1:0]                     id;
    logic [IFE_BLOCK_SIZE-1:0][IFE_INSTR_WIDTH-1:0]    instrs;
    logic [IFE_BLOCK_SIZE-1:0]                         mask;
  } ife_block_t;

  // Flat storage width of one entry for arbitrary parameter overrides.
  function automatic int ife_entry_width(input int id_w, input int instr_w, input int blk_sz);
    return id_w + instr_w * blk_sz + blk_sz;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ife_fifo_ptr_ctrl.sv
// ============================================================================
// Module      : ife_fifo_ptr_ctrl
// Description : Head/tail pointers, occupancy and flush control for the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ife_fifo_ptr_ctrl
  import ife_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push_req,
  input  logic             i_pop_req,
  output logic             o_push,
  output logic             o_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-2:0] o_wr_idx,
  output logic [CNT_W-2:0] o_rd_idx,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_head;
  logic [CNT_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_diff;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_diff   = r_tail - r_head;
  assign o_full   = (w_diff == CNT_W'(DEPTH));
  assign o_empty  = (r_tail == r_head);
  assign o_push   = i_push_req && !o_full && !i_flush;
  assign o_pop    = i_pop_req && !o_empty && !i_flush;
  assign o_wr_idx = r_tail[CNT_W-2:0];
  assign o_rd_idx = r_head[CNT_W-2:0];
  assign o_count  = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (o_push) r_tail <= r_tail + 1'b1;
      if (o_pop)  r_head <= r_head + 1'b1;
      case ({o_push, o_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ife_block_fifo.sv
// ============================================================================
// Module      : ife_block_fifo
// Description : Instruction block FIFO between block former and expander.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ife_block_fifo
  import ife_pkg::*;
#(
  parameter  int BLOCK_ID_WIDTH = IFE_BLOCK_ID_WIDTH,
  parameter  int INSTR_WIDTH    = IFE_INSTR_WIDTH,
  parameter  int BLOCK_SIZE     = IFE_BLOCK_SIZE,
  parameter  int DEPTH          = 8,
  parameter  int AF_THRESH      = DEPTH - 2,
  localparam int CNT_W          = $clog2(DEPTH) + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [BLOCK_ID_WIDTH-1:0]         block_id_in,
  input  logic [BLOCK_SIZE*INSTR_WIDTH-1:0] block_in,
  input  logic [BLOCK_SIZE-1:0]             mask_in,
  input  logic                              valid_in,
  output logic                              ready_in,
  output logic [BLOCK_ID_WIDTH-1:0]         block_id_out,
  output logic [BLOCK_SIZE*INSTR_WIDTH-1:0] block_out,
  output logic [BLOCK_SIZE-1:0]             mask_out,
  output logic                              valid_out,
  input  logic                              ready_downstream,
  output logic [CNT_W-1:0]                  count,
  output logic                              almost_full,
  output logic                              overflow_err
);

  localparam int ENTRY_W = ife_entry_width(BLOCK_ID_WIDTH, INSTR_WIDTH, BLOCK_SIZE);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic               r_overflow;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-2:0]   w_wr_idx;
  logic [CNT_W-2:0]   w_rd_idx;
  logic [CNT_W-1:0]   w_count;
  logic [ENTRY_W-1:0] w_head;

  ife_fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (flush),
    .i_push_req (valid_in),
    .i_pop_req  (ready_downstream),
    .o_push     (w_push),
    .o_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_wr_idx   (w_wr_idx),
    .o_rd_idx   (w_rd_idx),
    .o_count    (w_count)
  );

  // Storage is intentionally left unreset; outputs are qualified by valid_out.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_wr_idx] <= {block_id_in, block_in, mask_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               r_overflow <= 1'b0;
    else if (valid_in && w_full && !flush) r_overflow <= 1'b1;
  end

  assign w_head       = r_mem[w_rd_idx];
  assign block_id_out = w_head[ENTRY_W-1 -: BLOCK_ID_WIDTH];
  assign block_out    = w_head[BLOCK_SIZE +: BLOCK_SIZE*INSTR_WIDTH];
  assign mask_out     = w_head[BLOCK_SIZE-1:0];
  assign valid_out    = !w_empty;
  assign ready_in     = !w_full;
  assign count        = w_count;
  assign almost_full  = (w_count >= CNT_W'(AF_THRESH));
  assign overflow_err = r_overflow;

  // Pop handshake is consumed inside the pointer controller.
  logic w_unused;
  assign w_unused = w_pop;

endmodule

`default_nettype wire

// File: tb/tb_ife_block_fifo.sv
// ============================================================================
// Module      : tb_ife_block_fifo
// Description : Directed self-checking bench for ife_block_fifo (DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ife_block_fifo;

  localparam int IDW = 8;
  localparam int IW  = 32;
  localparam int BS  = 4;
  localparam int DEP = 8;
  localparam int CW  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic [IDW-1:0]    block_id_in = '0;
  logic [BS*IW-1:0]  block_in = '0;
  logic [BS-1:0]     mask_in = '0;
  logic              valid_in = 1'b0;
  logic              ready_in;
  logic [IDW-1:0]    block_id_out;
  logic [BS*IW-1:0]  block_out;
  logic [BS-1:0]     mask_out;
  logic              valid_out;
  logic              ready_downstream = 1'b0;
  logic [CW-1:0]     count;
  logic              almost_full;
  logic              overflow_err;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  ife_block_fifo #(
    .BLOCK_ID_WIDTH (IDW),
    .INSTR_WIDTH    (IW),
    .BLOCK_SIZE     (BS),
    .DEPTH          (DEP),
    .AF_THRESH      (DEP-2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .block_id_in      (block_id_in),
    .block_in         (block_in),
    .mask_in          (mask_in),
    .valid_in         (valid_in),
    .ready_in         (ready_in),
    .block_id_out     (block_id_out),
    .block_out        (block_out),
    .mask_out         (mask_out),
    .valid_out        (valid_out),
    .ready_downstream (ready_downstream),
    .count            (count),
    .almost_full      (almost_full),
    .overflow_err     (overflow_err)
  );

  always #5 clk = ~clk;

  // Payload pattern derived from the block ID so data corruption is visible.
  function automatic logic [BS*IW-1:0] mk_data(input logic [IDW-1:0] id);
    logic [BS*IW-1:0] d;
    for (int k = 0; k < BS; k++) d[k*IW +: IW] = {8'hC0 + 8'(k), 16'h1234, id};
    return d;
  endfunction

  function automatic logic [BS-1:0] mk_mask(input logic [IDW-1:0] id);
    return id[3:0] ^ 4'h5;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [IDW-1:0] id);
    valid_in    = v;
    block_id_in = id;
    block_in    = mk_data(id);
    mask_in     = mk_mask(id);
  endtask

  task automatic chk_head(input string tag, input logic [IDW-1:0] id);
    chk({tag, "_valid"}, 128'(valid_out), 128'(1'b1));
    chk({tag, "_id"},    128'(block_id_out), 128'(id));
    chk({tag, "_data"},  128'(block_out), 128'(mk_data(id)));
    chk({tag, "_mask"},  128'(mask_out), 128'(mk_mask(id)));
  endtask

  // Invariants and output stability under backpressure, sampled at negedge.
  logic             hold_q = 1'b0;
  logic [IDW-1:0]   id_q;
  logic [BS*IW-1:0] data_q;
  logic [BS-1:0]    mask_q;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (count > CW'(DEP)) begin
        fails++; $error("FAIL inv_count: observed %0d expected <= %0d", count, DEP);
      end
      if (count == CW'(DEP) && ready_in) begin
        fails++; $error("FAIL inv_push_full: observed ready_in=1 expected 0");
      end
      if (count == 0 && valid_out) begin
        fails++; $error("FAIL inv_pop_empty: observed valid_out=1 expected 0");
      end
      if (hold_q && (!valid_out || block_id_out !== id_q || block_out !== data_q || mask_out !== mask_q)) begin
        fails++; $error("FAIL inv_stable: observed id %0h expected %0h", block_id_out, id_q);
      end
      hold_q = valid_out && !ready_downstream && !flush;
      id_q   = block_id_out;
      data_q = block_out;
      mask_q = mask_out;
    end else begin
      hold_q = 1'b0;
    end
  end

  initial begin
    logic [IDW-1:0] exp_head;
    logic [IDW-1:0] nxt;

    // Reset state
    repeat (2) step();
    chk("rst_valid_out", 128'(valid_out), 128'(0));
    chk("rst_ready_in",  128'(ready_in), 128'(1));
    chk("rst_count",     128'(count), 128'(0));
    chk("rst_af",        128'(almost_full), 128'(0));
    chk("rst_ovf",       128'(overflow_err), 128'(0));
    rst = 1'b0;
    mon_en = 1'b1;
    step();
    chk("idle_valid_out", 128'(valid_out), 128'(0));

    // Fill with 0x10..0x17 under backpressure
    for (int i = 0; i < DEP; i++) begin
      drive(1'b1, 8'h10 + 8'(i));
      step();
      chk($sformatf("fill_count_%0d", i), 128'(count), 128'(i + 1));
      chk($sformatf("fill_af_%0d", i), 128'(almost_full), 128'(i + 1 >= 6));
      chk($sformatf("fill_rdy_%0d", i), 128'(ready_in), 128'(i + 1 < DEP));
    end
    chk_head("fill_head", 8'h10);

    // Overflow attempt while full
    drive(1'b1, 8'h99);
    step();
    drive(1'b0, 8'h00);
    chk("ovf_flag",  128'(overflow_err), 128'(1));
    chk("ovf_count", 128'(count), 128'(DEP));
    chk_head("ovf_head", 8'h10);

    // Drain in order
    ready_downstream = 1'b1;
    for (int i = 0; i < DEP; i++) begin
      chk_head($sformatf("drain_%0d", i), 8'h10 + 8'(i));
      step();
    end
    ready_downstream = 1'b0;
    chk("drain_count", 128'(count), 128'(0));
    chk("drain_valid", 128'(valid_out), 128'(0));
    chk("drain_af",    128'(almost_full), 128'(0));

    // Load 0x20..0x22, pop two so 0x22 is head
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h20 + 8'(i));
      step();
    end
    drive(1'b0, 8'h00);
    ready_downstream = 1'b1;
    repeat (2) step();
    ready_downstream = 1'b0;

    // Backpressure on head 0x22 for 5 cycles
    for (int i = 0; i < 5; i++) begin
      chk_head($sformatf("bp_%0d", i), 8'h22);
      step();
    end
    chk("bp_count", 128'(count), 128'(1));

    // Bring to count=3, then stream 20 cycles across the index wrap
    drive(1'b1, 8'h23); step();
    drive(1'b1, 8'h24); step();
    chk("pre_stream_count", 128'(count), 128'(3));
    exp_head = 8'h22;
    nxt      = 8'h25;
    ready_downstream = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("stream_id_%0d", i), 128'(block_id_out), 128'(exp_head));
      chk($sformatf("stream_cnt_%0d", i), 128'(count), 128'(3));
      drive(1'b1, nxt);
      step();
      exp_head = exp_head + 8'h01;
      nxt      = nxt + 8'h01;
    end
    ready_downstream = 1'b0;
    drive(1'b0, 8'h00);
    chk_head("post_stream", 8'h36);
    chk("post_stream_count", 128'(count), 128'(3));

    // Flush at count=5 with concurrent push and pop
    drive(1'b1, 8'h39); step();
    drive(1'b1, 8'h3A); step();
    chk("pre_flush_count", 128'(count), 128'(5));
    flush = 1'b1;
    ready_downstream = 1'b1;
    drive(1'b1, 8'h3B);
    step();
    flush = 1'b0;
    ready_downstream = 1'b0;
    drive(1'b0, 8'h00);
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_valid", 128'(valid_out), 128'(0));
    chk("flush_rdy",   128'(ready_in), 128'(1));
    chk("flush_ovf",   128'(overflow_err), 128'(1));
    drive(1'b1, 8'h40);
    step();
    drive(1'b0, 8'h00);
    chk_head("post_flush", 8'h40);
    chk("post_flush_count", 128'(count), 128'(1));

    // Asynchronous reset mid-cycle at count=4
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h41 + 8'(i));
      step();
    end
    drive(1'b0, 8'h00);
    chk("pre_rst_count", 128'(count), 128'(4));
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 128'(valid_out), 128'(0));
    chk("arst_count", 128'(count), 128'(0));
    chk("arst_ovf",   128'(overflow_err), 128'(0));
    chk("arst_rdy",   128'(ready_in), 128'(1));
    step();
    rst = 1'b0;
    mon_en = 1'b1;
    drive(1'b1, 8'h50);
    step();
    drive(1'b0, 8'h00);
    chk_head("resume", 8'h50);
    chk("resume_count", 128'(count), 128'(1));
    ready_downstream = 1'b1;
    step();
    ready_downstream = 1'b0;
    chk("resume_empty", 128'(valid_out), 128'(0));
    chk("resume_count0", 128'(count), 128'(0));

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
